id_stage_pipe: RTL and testbench

Parametrised decode stage for the MIPS pipelined CPU. It contains the register file, write-through bypass from writeback, and immediate extension. It also holds the ID/EX pipeline register with valid, stall and flush control. Optional load-use hazard detection requests a front-end stall. It sits between the IF/ID register and the execute stage.

---
 rtl/id_stage_pipe.sv | 155 +++++++++++++++
 tb/tb_id_stage_pipe.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// MIPS decode stage: register file with writeback bypass, immediate extension and ID/EX register.
// Define ID_HAZARD_EN to enable load-use hazard detection (otherwise hazard_stall is tied 0).
module id_stage_pipe #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [31:0]       instruction,
    input  logic [PC_W-1:0]   pc_in,
    input  logic              stall_in,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rt_addr,
    output logic              hazard_stall,
    output logic              id_valid,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [4:0]        rs_addr,
    output logic [4:0]        rt_addr,
    output logic [4:0]        rd_addr,
    output logic [DATA_W-1:0] ext_imm,
    output logic [4:0]        shamt,
    output logic [5:0]        opcode,
    output logic [5:0]        funct,
    output logic [PC_W-1:0]   pc_out
);

    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

    logic [DATA_W-1:0] r_regs [NREG];

    logic              r_id_valid;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [4:0]        r_rs_addr;
    logic [4:0]        r_rt_addr;
    logic [4:0]        r_rd_addr;
    logic [DATA_W-1:0] r_ext_imm;
    logic [4:0]        r_shamt;
    logic [5:0]        r_opcode;
    logic [5:0]        r_funct;
    logic [PC_W-1:0]   r_pc;

    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [5:0]        w_op;
    logic [15:0]       w_imm;
    logic              w_wr_en;
    logic              w_hazard;
    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W-1:0] w_rt_val;
    logic [DATA_W-1:0] w_ext;

    // Register 0 and addresses beyond NREG are not storage locations.
    function automatic logic addr_ok(input logic [4:0] a);
        return (a != 5'd0) && (32'(a) < 32'(NREG));
    endfunction

    assign w_rs    = instruction[25:21];
    assign w_rt    = instruction[20:16];
    assign w_op    = instruction[31:26];
    assign w_imm   = instruction[15:0];
    assign w_wr_en = wb_we && addr_ok(wb_addr);

`ifdef ID_HAZARD_EN
    assign w_hazard = !rst && if_valid && ex_mem_read && (ex_rt_addr != 5'd0) &&
                      ((ex_rt_addr == w_rs) || (ex_rt_addr == w_rt));
`else
    logic w_unused_hz;
    assign w_unused_hz = ex_mem_read ^ (^ex_rt_addr);
    assign w_hazard    = 1'b0;
`endif

    assign hazard_stall = w_hazard;

    always_comb begin
        w_rs_val = '0;
        w_rt_val = '0;
        if (addr_ok(w_rs))
            w_rs_val = (w_wr_en && (wb_addr == w_rs)) ? wb_data : r_regs[w_rs[AW-1:0]];
        if (addr_ok(w_rt))
            w_rt_val = (w_wr_en && (wb_addr == w_rt)) ? wb_data : r_regs[w_rt[AW-1:0]];
    end

    always_comb begin
        if ((w_op == 6'h0C) || (w_op == 6'h0D) || (w_op == 6'h0E))
            w_ext = DATA_W'(w_imm);
        else
            w_ext = DATA_W'($signed(w_imm));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++)
                r_regs[i] <= '0;
        end else if (w_wr_en) begin
            r_regs[wb_addr[AW-1:0]] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_valid <= 1'b0;
            r_rs_data  <= '0;
            r_rt_data  <= '0;
            r_rs_addr  <= '0;
            r_rt_addr  <= '0;
            r_rd_addr  <= '0;
            r_ext_imm  <= '0;
            r_shamt    <= '0;
            r_opcode   <= '0;
            r_funct    <= '0;
            r_pc       <= '0;
        end else if (stall_in || w_hazard) begin
            // Held operands still track writebacks so they never go stale.
            if (!stall_in)
                r_id_valid <= 1'b0;
            if (w_wr_en && (wb_addr == r_rs_addr))
                r_rs_data <= wb_data;
            if (w_wr_en && (wb_addr == r_rt_addr))
                r_rt_data <= wb_data;
        end else begin
            r_id_valid <= if_valid && !flush;
            r_rs_data  <= w_rs_val;
            r_rt_data  <= w_rt_val;
            r_rs_addr  <= w_rs;
            r_rt_addr  <= w_rt;
            r_rd_addr  <= instruction[15:11];
            r_ext_imm  <= w_ext;
            r_shamt    <= instruction[10:6];
            r_opcode   <= w_op;
            r_funct    <= instruction[5:0];
            r_pc       <= pc_in;
        end
    end

    assign id_valid = r_id_valid;
    assign rs_data  = r_rs_data;
    assign rt_data  = r_rt_data;
    assign rs_addr  = r_rs_addr;
    assign rt_addr  = r_rt_addr;
    assign rd_addr  = r_rd_addr;
    assign ext_imm  = r_ext_imm;
    assign shamt    = r_shamt;
    assign opcode   = r_opcode;
    assign funct    = r_funct;
    assign pc_out   = r_pc;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: reference model compared every cycle plus literal spot checks.
// Main DUT uses NREG=16 to exercise dropped writes; a DATA_W=64 copy checks wide sign extension.
module tb_id_stage_pipe;

    localparam int NREG = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] instruction;
    logic [31:0] pc_in;
    logic        stall_in;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_mem_read;
    logic [4:0]  ex_rt_addr;

    logic        hazard_stall, id_valid;
    logic [31:0] rs_data, rt_data, ext_imm, pc_out;
    logic [4:0]  rs_addr, rt_addr, rd_addr, shamt;
    logic [5:0]  opcode, funct;

    logic [63:0] wb_data64;
    logic        h64, v64;
    logic [63:0] rs64, rt64, ext64;
    logic [4:0]  rsa64, rta64, rda64, sh64;
    logic [5:0]  op64, fn64;
    logic [31:0] pc64;

    assign wb_data64 = {32'h0, wb_data};

    always #5 clk = ~clk;

    id_stage_pipe #(.DATA_W(32), .NREG(NREG), .PC_W(32)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .instruction(instruction), .pc_in(pc_in),
        .stall_in(stall_in), .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_mem_read(ex_mem_read), .ex_rt_addr(ex_rt_addr), .hazard_stall(hazard_stall),
        .id_valid(id_valid), .rs_data(rs_data), .rt_data(rt_data), .rs_addr(rs_addr),
        .rt_addr(rt_addr), .rd_addr(rd_addr), .ext_imm(ext_imm), .shamt(shamt),
        .opcode(opcode), .funct(funct), .pc_out(pc_out)
    );

    id_stage_pipe #(.DATA_W(64), .NREG(32), .PC_W(32)) dut64 (
        .clk(clk), .rst(rst), .if_valid(if_valid), .instruction(instruction), .pc_in(pc_in),
        .stall_in(stall_in), .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data64),
        .ex_mem_read(ex_mem_read), .ex_rt_addr(ex_rt_addr), .hazard_stall(h64),
        .id_valid(v64), .rs_data(rs64), .rt_data(rt64), .rs_addr(rsa64),
        .rt_addr(rta64), .rd_addr(rda64), .ext_imm(ext64), .shamt(sh64),
        .opcode(op64), .funct(fn64), .pc_out(pc64)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    // Reference state: architectural registers and expected ID/EX contents.
    logic [31:0] m_regs [32];
    logic        e_valid;
    logic [31:0] e_rs_data, e_rt_data, e_ext, e_pc;
    logic [4:0]  e_rs, e_rt, e_rd, e_sh;
    logic [5:0]  e_op, e_fn;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mread(input logic [4:0] a);
        if (a == 0 || int'(a) >= NREG) return 32'h0;
        return m_regs[a];
    endfunction

    function automatic logic [31:0] extend(input logic [5:0] op, input logic [15:0] imm);
        if (op == 6'h0C || op == 6'h0D || op == 6'h0E) return {16'h0, imm};
        return (imm >= 16'h8000) ? (32'hFFFF0000 + 32'(imm)) : 32'(imm);
    endfunction

    function automatic logic model_hazard();
`ifdef ID_HAZARD_EN
        return !rst && if_valid && ex_mem_read && ex_rt_addr != 0 &&
               (ex_rt_addr == instruction[25:21] || ex_rt_addr == instruction[20:16]);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_edge();
        logic wr, hz;
        wr = wb_we && wb_addr != 0 && int'(wb_addr) < NREG;
        hz = model_hazard();
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            e_valid = 0; e_rs_data = 0; e_rt_data = 0; e_ext = 0; e_pc = 0;
            e_rs = 0; e_rt = 0; e_rd = 0; e_sh = 0; e_op = 0; e_fn = 0;
        end else begin
            if (stall_in || hz) begin
                if (!stall_in) e_valid = 0;
                if (wr && wb_addr == e_rs) e_rs_data = wb_data;
                if (wr && wb_addr == e_rt) e_rt_data = wb_data;
            end else begin
                e_rs = instruction[25:21];
                e_rt = instruction[20:16];
                e_rd = instruction[15:11];
                e_sh = instruction[10:6];
                e_op = instruction[31:26];
                e_fn = instruction[5:0];
                e_rs_data = (wr && wb_addr == e_rs) ? wb_data : mread(e_rs);
                e_rt_data = (wr && wb_addr == e_rt) ? wb_data : mread(e_rt);
                e_ext = extend(e_op, instruction[15:0]);
                e_pc = pc_in;
                e_valid = if_valid && !flush;
            end
            if (wr) m_regs[wb_addr] = wb_data;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        pc_in = pc_in + 32'd4;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("id_valid", 64'(id_valid), 64'(e_valid));
            check("rs_data", 64'(rs_data), 64'(e_rs_data));
            check("rt_data", 64'(rt_data), 64'(e_rt_data));
            check("rs_addr", 64'(rs_addr), 64'(e_rs));
            check("rt_addr", 64'(rt_addr), 64'(e_rt));
            check("rd_addr", 64'(rd_addr), 64'(e_rd));
            check("shamt", 64'(shamt), 64'(e_sh));
            check("opcode", 64'(opcode), 64'(e_op));
            check("funct", 64'(funct), 64'(e_fn));
            check("ext_imm", 64'(ext_imm), 64'(e_ext));
            check("pc_out", 64'(pc_out), 64'(e_pc));
            check("hazard_stall", 64'(hazard_stall), 64'(model_hazard()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct { logic [31:0] ins; logic [31:0] exp; } imm_t;
    imm_t imm_tab [5];

    initial begin
        rst = 1; if_valid = 0; instruction = 0; pc_in = 32'h0040_0000; stall_in = 0; flush = 0;
        wb_we = 0; wb_addr = 0; wb_data = 0; ex_mem_read = 0; ex_rt_addr = 0;
        step();
        rst = 0;
        chk_en = 1;
        check("reset_id_valid", 64'(id_valid), 64'h0);
        check("reset_rs_data", 64'(rs_data), 64'h0);

        // Read every register address after reset
        if_valid = 1;
        for (int i = 0; i < 32; i++) begin
            instruction = {6'h0, 5'(i), 5'(31 - i), 16'h0};
            step();
        end
        check("post_reset_rs", 64'(rs_data), 64'h0);
        check("post_reset_rt", 64'(rt_data), 64'h0);

        // Write-before-read bypass
        wb_we = 1; wb_addr = 5; wb_data = 32'hDEADBEEF; instruction = 32'h00A53020;
        step();
        wb_we = 0;
        check("bypass_rs", 64'(rs_data), 64'hDEADBEEF);
        check("bypass_rt", 64'(rt_data), 64'hDEADBEEF);
        check("bypass_rd", 64'(rd_addr), 64'h6);
        check("bypass_valid", 64'(id_valid), 64'h1);
        instruction = 32'h00A04020;
        step();
        check("reread_5", 64'(rs_data), 64'hDEADBEEF);

        // $0 write ignored, $20 out of range with NREG=16, $15 top legal register
        wb_we = 1; wb_addr = 0; wb_data = 32'h1234; step();
        wb_we = 0; instruction = 32'h00001020; step();
        check("zero_reg", 64'(rs_data), 64'h0);
        wb_we = 1; wb_addr = 20; wb_data = 32'hABCD; step();
        wb_we = 0; instruction = 32'h02800000; step();
        check("dropped_20", 64'(rs_data), 64'h0);
        wb_we = 1; wb_addr = 15; wb_data = 32'h77; step();
        wb_we = 0; instruction = 32'h01E00000; step();
        check("reg_15", 64'(rs_data), 64'h77);

        // Immediate extension
        imm_tab[0] = '{32'h34018001, 32'h00008001};
        imm_tab[1] = '{32'h20018001, 32'hFFFF8001};
        imm_tab[2] = '{32'h30018001, 32'h00008001};
        imm_tab[3] = '{32'h38018001, 32'h00008001};
        imm_tab[4] = '{32'h3C018001, 32'hFFFF8001};
        for (int i = 0; i < 5; i++) begin
            instruction = imm_tab[i].ins;
            step();
            check("ext_imm_lit", 64'(ext_imm), 64'(imm_tab[i].exp));
            if (i == 1) check("ext_imm_64", ext64, 64'hFFFFFFFFFFFF8001);
        end

        // Load-use hazard
        instruction = 32'h00000000; step();
        ex_mem_read = 1; ex_rt_addr = 8; instruction = 32'h01094020;
        #1;
`ifdef ID_HAZARD_EN
        check("hazard_now", 64'(hazard_stall), 64'h1);
        step();
        check("hazard_bubble", 64'(id_valid), 64'h0);
        check("hazard_hold_rs", 64'(rs_addr), 64'h0);
        ex_mem_read = 0;
        step();
        check("hazard_release", 64'(id_valid), 64'h1);
        check("hazard_rs", 64'(rs_addr), 64'h8);
`else
        check("hazard_off", 64'(hazard_stall), 64'h0);
        step();
        check("no_hazard_load", 64'(id_valid), 64'h1);
        check("no_hazard_rs", 64'(rs_addr), 64'h8);
        ex_mem_read = 0;
`endif
        ex_rt_addr = 0;

        // Stall with writeback refresh, stall+flush, then flush
        instruction = 32'h012A5820; step();
        stall_in = 1; wb_we = 1; wb_addr = 9; wb_data = 32'h55; instruction = 32'h0;
        step();
        wb_we = 0;
        check("stall_refresh_rs", 64'(rs_data), 64'h55);
        check("stall_hold_rd", 64'(rd_addr), 64'hB);
        check("stall_hold_valid", 64'(id_valid), 64'h1);
        flush = 1; step();
        check("stall_flush_valid", 64'(id_valid), 64'h1);
        stall_in = 0; step();
        check("flush_valid", 64'(id_valid), 64'h0);
        flush = 0;

        // Mixed traffic
        for (int i = 0; i < 12; i++) begin
            wb_we = 1; wb_addr = 5'(i * 3); wb_data = 32'h1000_0000 + 32'(i * 17);
            instruction = {((i % 2) == 0) ? 6'h08 : 6'h0D, 5'(i * 3), 5'(i * 3 - 3), 16'(i * 32'h1111)};
            if_valid = (i % 4) != 3;
            flush = (i % 5) == 4;
            stall_in = (i % 6) == 5;
            step();
        end
        wb_we = 0; flush = 0; stall_in = 0; if_valid = 1;

        // Reset while stalled clears everything
        stall_in = 1; rst = 1; step();
        rst = 0; stall_in = 0;
        check("rst_stall_valid", 64'(id_valid), 64'h0);
        instruction = 32'h00A00000; step();
        check("rst_cleared_5", 64'(rs_data), 64'h0);
        step();

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
